// File: rtl/dsp_sel_ctrl_pkg.sv
// rtl/dsp_sel_ctrl_pkg.sv - shared mode codes and default parameters for the display-select controller
package dsp_sel_ctrl_pkg;

    typedef enum logic [1:0] {
        DSEL_SWITCH = 2'd0,
        DSEL_MANUAL = 2'd1,
        DSEL_AUTO   = 2'd2
    } dsel_mode_e;

    localparam int          DEF_DEB_TICKS   = 4;
    localparam int          DEF_AUTO_TICKS  = 1000;
    localparam logic [15:0] DEF_SKIP_MASK   = 16'h0C00;
    localparam logic [3:0]  DEF_DIRECT_CODE = 4'd10;

    // Mode button cycles SWITCH -> MANUAL -> AUTO -> SWITCH; the unused code falls back to SWITCH.
    function automatic dsel_mode_e next_mode(input dsel_mode_e m);
        case (m)
            DSEL_SWITCH: return DSEL_MANUAL;
            DSEL_MANUAL: return DSEL_AUTO;
            default:     return DSEL_SWITCH;
        endcase
    endfunction

endpackage

// File: rtl/dsp_sel_ctrl_if.sv
// rtl/dsp_sel_ctrl_if.sv - board-side inputs and mux/seg7 control outputs of the display-select controller
interface dsp_sel_ctrl_if;
    logic       tick;
    logic       btn_next;
    logic       btn_prev;
    logic       btn_mode;
    logic [3:0] sw_sel;
    logic [3:0] sel;
    logic       direct;
    logic [1:0] mode;
    logic       sel_chg;

    modport master (
        output tick, btn_next, btn_prev, btn_mode, sw_sel,
        input  sel, direct, mode, sel_chg
    );

    modport slave (
        input  tick, btn_next, btn_prev, btn_mode, sw_sel,
        output sel, direct, mode, sel_chg
    );
endinterface

// File: rtl/dsp_sel_ctrl_btn_debounce.sv
// rtl/dsp_sel_ctrl_btn_debounce.sv - button synchroniser, tick-sampled debouncer and press pulse
module dsp_sel_ctrl_btn_debounce #(
    parameter int DEB_TICKS = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic btn,
    output logic press
);
    localparam int CW = $clog2(DEB_TICKS + 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          level_q, level_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          press_q, press_d;

    // Count consecutive tick samples that disagree with the accepted level; flip after DEB_TICKS of them.
    always_comb begin
        sync1_d = btn;
        sync2_d = sync1_q;
        level_d = level_q;
        cnt_d   = cnt_q;
        press_d = 1'b0;
        if (tick) begin
            if (sync2_q != level_q) begin
                if (cnt_q == CW'(DEB_TICKS - 1)) begin
                    level_d = ~level_q;
                    cnt_d   = '0;
                    press_d = ~level_q;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end else begin
                cnt_d = '0;
            end
        end
    end

    // State registers; reset reports the button released and drops any partial count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign press = press_q;
endmodule

// File: rtl/dsp_sel_ctrl.sv
// rtl/dsp_sel_ctrl.sv - display-source select controller with switch, manual-step and auto-rotate modes
module dsp_sel_ctrl
    import dsp_sel_ctrl_pkg::*;
#(
    parameter int          DEB_TICKS   = DEF_DEB_TICKS,
    parameter int          AUTO_TICKS  = DEF_AUTO_TICKS,
    parameter logic [15:0] SKIP_MASK   = DEF_SKIP_MASK,
    parameter logic [3:0]  DIRECT_CODE = DEF_DIRECT_CODE
) (
    input  logic           clk,
    input  logic           reset,
    dsp_sel_ctrl_if.slave  bus
);
    logic press_next, press_prev, press_mode;

    dsp_sel_ctrl_btn_debounce #(.DEB_TICKS(DEB_TICKS)) u_deb_next (
        .clk(clk), .reset(reset), .tick(bus.tick), .btn(bus.btn_next), .press(press_next)
    );
    dsp_sel_ctrl_btn_debounce #(.DEB_TICKS(DEB_TICKS)) u_deb_prev (
        .clk(clk), .reset(reset), .tick(bus.tick), .btn(bus.btn_prev), .press(press_prev)
    );
    dsp_sel_ctrl_btn_debounce #(.DEB_TICKS(DEB_TICKS)) u_deb_mode (
        .clk(clk), .reset(reset), .tick(bus.tick), .btn(bus.btn_mode), .press(press_mode)
    );

    // First non-skipped code above cur (wrapping); cur itself is returned when all others are skipped.
    function automatic logic [3:0] next_code(input logic [3:0] cur);
        logic [3:0] res;
        logic [3:0] c;
        logic       found;
        res   = cur;
        found = 1'b0;
        for (int i = 1; i < 16; i++) begin
            c = cur + 4'(i);
            if (!found && !SKIP_MASK[c]) begin
                res   = c;
                found = 1'b1;
            end
        end
        return res;
    endfunction

    // First non-skipped code below cur (wrapping); cur itself is returned when all others are skipped.
    function automatic logic [3:0] prev_code(input logic [3:0] cur);
        logic [3:0] res;
        logic [3:0] c;
        logic       found;
        res   = cur;
        found = 1'b0;
        for (int i = 1; i < 16; i++) begin
            c = cur - 4'(i);
            if (!found && !SKIP_MASK[c]) begin
                res   = c;
                found = 1'b1;
            end
        end
        return res;
    endfunction

    dsel_mode_e  mode_q, mode_d;
    logic [3:0]  sel_q, sel_d;
    logic        direct_q, direct_d;
    logic        sel_chg_q, sel_chg_d;
    logic [15:0] auto_cnt_q, auto_cnt_d;
    logic        step_req;

    // Mode FSM and select update: a mode press pre-empts stepping, next+prev together cancel out.
    always_comb begin
        mode_d     = mode_q;
        sel_d      = sel_q;
        auto_cnt_d = auto_cnt_q;
        step_req   = press_next ^ press_prev;
        if (press_mode) begin
            mode_d = next_mode(mode_q);
            if (mode_d == DSEL_AUTO) begin
                auto_cnt_d = '0;
            end
        end else begin
            case (mode_q)
                DSEL_SWITCH: begin
                    sel_d = bus.sw_sel;
                end
                DSEL_MANUAL: begin
                    if (step_req) begin
                        sel_d = press_next ? next_code(sel_q) : prev_code(sel_q);
                    end
                end
                DSEL_AUTO: begin
                    if (step_req) begin
                        sel_d      = press_next ? next_code(sel_q) : prev_code(sel_q);
                        auto_cnt_d = '0;
                    end else if (bus.tick) begin
                        if (auto_cnt_q == 16'(AUTO_TICKS - 1)) begin
                            auto_cnt_d = '0;
                            sel_d      = next_code(sel_q);
                        end else begin
                            auto_cnt_d = auto_cnt_q + 16'd1;
                        end
                    end
                end
                default: begin
                    mode_d = DSEL_SWITCH;
                end
            endcase
        end
        direct_d  = (sel_d == DIRECT_CODE);
        sel_chg_d = (sel_d != sel_q);
    end

    // Registered outputs so sel, direct and sel_chg all change together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q     <= DSEL_SWITCH;
            sel_q      <= 4'd0;
            direct_q   <= (DIRECT_CODE == 4'd0);
            sel_chg_q  <= 1'b0;
            auto_cnt_q <= '0;
        end else begin
            mode_q     <= mode_d;
            sel_q      <= sel_d;
            direct_q   <= direct_d;
            sel_chg_q  <= sel_chg_d;
            auto_cnt_q <= auto_cnt_d;
        end
    end

    assign bus.sel     = sel_q;
    assign bus.direct  = direct_q;
    assign bus.mode    = mode_q;
    assign bus.sel_chg = sel_chg_q;
endmodule

// File: tb/tb_dsp_sel_ctrl.sv
// tb/tb_dsp_sel_ctrl.sv - randomized and directed self-checking bench for dsp_sel_ctrl
module tb_dsp_sel_ctrl;
    localparam int          DEB  = 4;
    localparam int          AT   = 3;
    localparam logic [15:0] SKIP = 16'h0C00;
    localparam int          DC   = 10;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dsp_sel_ctrl_if bus();

    dsp_sel_ctrl #(
        .DEB_TICKS(DEB), .AUTO_TICKS(AT), .SKIP_MASK(SKIP), .DIRECT_CODE(4'(DC))
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;
    logic [15:0] skip_v = SKIP;

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: button levels are accepted once the last DEB tick samples all disagree with them.
    bit m_sy1[3], m_sy2[3], m_acc[3], m_pr[3], m_np[3], m_raw[3];
    bit m_hist[3][$];
    bit m_all;
    bit m_chg;
    int m_sel, m_mode, m_cnt, m_prev;

    function automatic int step_to(input int s, input bit up);
        int c;
        for (int d = 1; d < 16; d++) begin
            c = up ? (s + d) % 16 : (s + 16 - d) % 16;
            if (!skip_v[c]) return c;
        end
        return s;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int b = 0; b < 3; b++) begin
                m_sy1[b] = 0; m_sy2[b] = 0; m_acc[b] = 0; m_pr[b] = 0; m_np[b] = 0;
                m_hist[b].delete();
            end
            m_sel = 0; m_mode = 0; m_cnt = 0; m_chg = 0;
        end else begin
            m_raw[0] = bus.btn_next;
            m_raw[1] = bus.btn_prev;
            m_raw[2] = bus.btn_mode;
            for (int b = 0; b < 3; b++) begin
                m_np[b] = 0;
                if (bus.tick) begin
                    m_hist[b].push_back(m_sy2[b]);
                    if (m_hist[b].size() > DEB) void'(m_hist[b].pop_front());
                    if (m_hist[b].size() == DEB) begin
                        m_all = 1;
                        for (int k = 0; k < m_hist[b].size(); k++)
                            if (m_hist[b][k] == m_acc[b]) m_all = 0;
                        if (m_all) begin
                            m_acc[b] = !m_acc[b];
                            m_np[b]  = m_acc[b];
                        end
                    end
                end
                m_sy2[b] = m_sy1[b];
                m_sy1[b] = m_raw[b];
            end
            m_prev = m_sel;
            if (m_pr[2]) begin
                m_mode = (m_mode + 1) % 3;
                if (m_mode == 2) m_cnt = 0;
            end else if (m_mode == 0) begin
                m_sel = int'(bus.sw_sel);
            end else if (m_pr[0] != m_pr[1]) begin
                m_sel = step_to(m_sel, m_pr[0]);
                m_cnt = 0;
            end else if (m_mode == 2 && bus.tick) begin
                m_cnt = m_cnt + 1;
                if (m_cnt == AT) begin
                    m_cnt = 0;
                    m_sel = step_to(m_sel, 1'b1);
                end
            end
            m_chg = (m_sel != m_prev);
            for (int b = 0; b < 3; b++) m_pr[b] = m_np[b];
        end
    end

    // Every-cycle comparison against the model while out of reset.
    always @(negedge clk) begin
        if (chk_on && !reset) begin
            check("sel", int'(bus.sel), m_sel);
            check("mode", int'(bus.mode), m_mode);
            check("direct", int'(bus.direct), int'(m_sel == DC));
            check("sel_chg", int'(bus.sel_chg), int'(m_chg));
        end
    end

    task automatic tick_n(input int n);
        repeat (n) begin
            @(negedge clk); bus.tick = 1'b1;
            @(negedge clk); bus.tick = 1'b0;
        end
    endtask

    task automatic set_btns(input logic [2:0] m);
        bus.btn_mode = m[2];
        bus.btn_prev = m[1];
        bus.btn_next = m[0];
    endtask

    // m = {mode, prev, next}; returns two clocks after the accepted press has been applied.
    task automatic press(input logic [2:0] m);
        set_btns(3'b000);
        repeat (2) @(negedge clk);
        tick_n(DEB);
        set_btns(m);
        repeat (2) @(negedge clk);
        tick_n(DEB);
        set_btns(3'b000);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int auto_exp[3] = '{9, 12, 13};

    initial begin
        reset = 1'b0;
        bus.tick = 1'b0;
        set_btns(3'b000);
        bus.sw_sel = 4'd5;
        #1 reset = 1'b1;
        #1;
        check("reset_sel", int'(bus.sel), 0);
        check("reset_mode", int'(bus.mode), 0);
        check("reset_direct", int'(bus.direct), 0);
        check("reset_chg", int'(bus.sel_chg), 0);
        @(negedge clk) reset = 1'b0;
        chk_on = 1'b1;
        @(negedge clk);
        check("sw_follow_sel", int'(bus.sel), 5);
        check("sw_follow_chg", int'(bus.sel_chg), 1);
        @(negedge clk);
        check("sw_follow_chg_once", int'(bus.sel_chg), 0);

        // Debounce: 3-tick hold and a bouncing button give no event, a 4-tick hold does.
        bus.btn_mode = 1'b1;
        repeat (2) @(negedge clk);
        tick_n(3);
        bus.btn_mode = 1'b0;
        repeat (2) @(negedge clk);
        tick_n(DEB);
        check("short_hold_mode", int'(bus.mode), 0);
        for (int i = 0; i < 4; i++) begin
            bus.btn_mode = (i % 2 == 0);
            repeat (2) @(negedge clk);
            tick_n(1);
        end
        bus.btn_mode = 1'b0;
        check("bounce_mode", int'(bus.mode), 0);
        press(3'b100);
        check("full_hold_mode", int'(bus.mode), 1);
        check("full_hold_sel", int'(bus.sel), 5);

        // Manual stepping around skipped codes and the wrap points.
        @(negedge clk) reset = 1'b1; bus.sw_sel = 4'd9;
        @(negedge clk) reset = 1'b0;
        @(negedge clk);
        check("sw_sel9", int'(bus.sel), 9);
        press(3'b100);
        check("manual_mode", int'(bus.mode), 1);
        check("manual_keep", int'(bus.sel), 9);
        press(3'b001);
        check("next_9", int'(bus.sel), 12);
        press(3'b010);
        check("prev_12", int'(bus.sel), 9);
        press(3'b001); press(3'b001); press(3'b001); press(3'b001);
        check("next_to_15", int'(bus.sel), 15);
        press(3'b001);
        check("next_15_wrap", int'(bus.sel), 0);
        press(3'b010);
        check("prev_0_wrap", int'(bus.sel), 15);

        // Auto-rotate from 8 with AUTO_TICKS=3.
        for (int i = 0; i < 5; i++) press(3'b010);
        check("prev_to_8", int'(bus.sel), 8);
        bus.sw_sel = 4'd10;
        press(3'b100);
        check("auto_mode", int'(bus.mode), 2);
        check("auto_keep", int'(bus.sel), 8);
        for (int k = 0; k < 3; k++) begin
            tick_n(AT);
            check("auto_step", int'(bus.sel), auto_exp[k]);
        end

        // Direct flag on code 10 entered through SWITCH, cleared when stepping off it.
        press(3'b100);
        check("back_switch", int'(bus.mode), 0);
        check("sw_sel10", int'(bus.sel), 10);
        check("direct_on", int'(bus.direct), 1);
        press(3'b100);
        check("manual_on_10", int'(bus.sel), 10);
        press(3'b001);
        check("next_10", int'(bus.sel), 12);
        check("direct_off", int'(bus.direct), 0);

        // Simultaneous events.
        press(3'b011);
        check("next_prev_sel", int'(bus.sel), 12);
        check("next_prev_chg", int'(bus.sel_chg), 0);
        press(3'b101);
        check("mode_next_mode", int'(bus.mode), 2);
        check("mode_next_sel", int'(bus.sel), 12);

        // Asynchronous reset mid-AUTO and mid-debounce.
        bus.btn_next = 1'b1;
        repeat (2) @(negedge clk);
        tick_n(2);
        #2 reset = 1'b1;
        #1;
        check("async_sel", int'(bus.sel), 0);
        check("async_mode", int'(bus.mode), 0);
        check("async_direct", int'(bus.direct), 0);
        check("async_chg", int'(bus.sel_chg), 0);
        @(negedge clk) reset = 1'b0; bus.btn_next = 1'b0; bus.btn_mode = 1'b1;
        repeat (2) @(negedge clk);
        tick_n(DEB - 1);
        check("post_reset_partial", int'(bus.mode), 0);
        tick_n(1);
        @(negedge clk);
        check("post_reset_full", int'(bus.mode), 1);
        bus.btn_mode = 1'b0;

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (reset) reset = 1'b0;
            else if ($urandom_range(0, 699) == 0) reset = 1'b1;
            bus.tick = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 11) == 0) bus.btn_next = ~bus.btn_next;
            if ($urandom_range(0, 11) == 0) bus.btn_prev = ~bus.btn_prev;
            if ($urandom_range(0, 13) == 0) bus.btn_mode = ~bus.btn_mode;
            if ($urandom_range(0, 19) == 0) bus.sw_sel = 4'($urandom_range(0, 15));
        end
        @(negedge clk);
        bus.tick = 1'b0;
        reset = 1'b0;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
